// File: rtl/panel_scan_if.sv
// panel_scan_if: pixel ROM bus between the scan driver (master) and the
// 8-image pixel ROM (slave). The ROM answers combinationally: rgb follows
// addr/img within the same cycle.
interface panel_scan_if;
  logic [8:0]  addr;  // {half, row[2:0], col[4:0]}
  logic [2:0]  img;
  logic [23:0] rgb;   // R=[23:16], G=[15:8], B=[7:0]

  modport master (output addr, output img, input rgb);
  modport slave  (input addr, input img, output rgb);
endinterface

// File: rtl/panel_scan.sv
// panel_scan: HUB75 1/8-scan driver for a 32x16 RGB panel with binary-code
// modulated bit planes. Fetches each column pair from the pixel ROM over
// panel_scan_if, shifts it out, latches, then enables the LEDs for a
// plane-weighted time.
//
// Optional build macro PANEL_SCAN_ANIM_EN: when defined, the ROM image select
// steps once every FRAMES_PER_IMG refreshes (7 wraps to 0). When undefined,
// img is tied to 0 and the frame counter does not exist.
//
// state     | meaning
// S_SHIFT   | fetch top/bottom pixels and clock 32 columns out, 4 cycles each
// S_BLANK   | LEDs off, panel_clk low, row select updated
// S_LATCH   | one-cycle latch strobe, load display timer
// S_DISPLAY | LEDs on for BASE_TICKS<<plane cycles, then step plane/row
module panel_scan #(
  parameter int PWM_BITS       = 4,
  parameter int BASE_TICKS     = 8,
  parameter int FRAMES_PER_IMG = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  panel_scan_if.master rom,
  output logic         panel_r1,
  output logic         panel_g1,
  output logic         panel_b1,
  output logic         panel_r2,
  output logic         panel_g2,
  output logic         panel_b2,
  output logic [2:0]   panel_a,
  output logic         panel_clk,
  output logic         panel_lat,
  output logic         panel_oe_n,
  output logic         frame_start
);

  localparam int TICK_W  = $clog2(BASE_TICKS << (PWM_BITS - 1)) + 1;
  localparam int PLANE_W = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PWM_BITS - 1);

  typedef enum logic [1:0] {S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

  state_t             state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [4:0]         col_q, col_d;
  logic [1:0]         phase_q, phase_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [23:0]        top_q, top_d;
  logic [8:0]         addr_q, addr_d;
  logic [5:0]         data_q, data_d;   // {r1, g1, b1, r2, g2, b2}
  logic [2:0]         pa_q, pa_d;
  logic               pclk_q, pclk_d;
  logic               lat_q, lat_d;
  logic               oe_n_q, oe_n_d;
  logic               fs_q, fs_d;
  logic [2:0]         bit_sel;

  // Only the top PWM_BITS bits of each channel are displayed.
  assign bit_sel = 3'(8 - PWM_BITS) + 3'(plane_q);

  // Next-state and next-output logic; every panel pin is registered.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    col_d   = col_q;
    phase_d = phase_q;
    tick_d  = tick_q;
    top_d   = top_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pa_d    = pa_q;
    pclk_d  = 1'b0;
    lat_d   = 1'b0;
    oe_n_d  = 1'b1;
    fs_d    = 1'b0;
    case (state_q)
      S_SHIFT: begin
        phase_d = phase_q + 2'd1;
        case (phase_q)
          2'd0: begin
            addr_d = {1'b0, row_q, col_q};
            fs_d   = (row_q == 3'd0) && (plane_q == '0) && (col_q == 5'd0);
          end
          2'd1: begin
            top_d  = rom.rgb;
            addr_d = {1'b1, row_q, col_q};
          end
          2'd2: begin
            data_d = {top_q[{2'b10, bit_sel}], top_q[{2'b01, bit_sel}],
                      top_q[{2'b00, bit_sel}], rom.rgb[{2'b10, bit_sel}],
                      rom.rgb[{2'b01, bit_sel}], rom.rgb[{2'b00, bit_sel}]};
          end
          default: begin
            pclk_d = 1'b1;
            col_d  = col_q + 5'd1;
            if (col_q == 5'd31) state_d = S_BLANK;
          end
        endcase
      end
      S_BLANK: begin
        pa_d    = row_q;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        lat_d   = 1'b1;
        tick_d  = TICK_W'((BASE_TICKS << plane_q) - 1);
        state_d = S_DISPLAY;
      end
      default: begin
        oe_n_d = 1'b0;
        if (tick_q == '0) begin
          state_d = S_SHIFT;
          if (plane_q == LAST_PLANE) begin
            plane_d = '0;
            row_d   = row_q + 3'd1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
    endcase
  end

  // State and output registers; oe_n resets high so LEDs blank immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SHIFT;
      row_q   <= '0;
      plane_q <= '0;
      col_q   <= '0;
      phase_q <= '0;
      tick_q  <= '0;
      top_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      pa_q    <= '0;
      pclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      top_q   <= top_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pa_q    <= pa_d;
      pclk_q  <= pclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      fs_q    <= fs_d;
    end
  end

`ifdef PANEL_SCAN_ANIM_EN
  localparam int FC_W = (FRAMES_PER_IMG > 1) ? $clog2(FRAMES_PER_IMG) : 1;

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]      img_q, img_d;
  logic            frame_end;

  // The last display cycle of row 7's last plane closes the frame, so img
  // can only change between frames.
  assign frame_end = (state_q == S_DISPLAY) && (tick_q == '0) &&
                     (plane_q == LAST_PLANE) && (row_q == 3'd7);

  // Refresh counter and image step.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    img_d       = img_q;
    if (frame_end) begin
      if (frame_cnt_q == FC_W'(FRAMES_PER_IMG - 1)) begin
        frame_cnt_d = '0;
        img_d       = img_q + 3'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Animation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      img_q       <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      img_q       <= img_d;
    end
  end

  assign rom.img = img_q;
`else
  assign rom.img = 3'd0;
`endif

  assign rom.addr    = addr_q;
  assign panel_r1    = data_q[5];
  assign panel_g1    = data_q[4];
  assign panel_b1    = data_q[3];
  assign panel_r2    = data_q[2];
  assign panel_g2    = data_q[1];
  assign panel_b2    = data_q[0];
  assign panel_a     = pa_q;
  assign panel_clk   = pclk_q;
  assign panel_lat   = lat_q;
  assign panel_oe_n  = oe_n_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_panel_scan.sv
// tb_panel_scan: self-checking bench for panel_scan with PWM_BITS=4,
// BASE_TICKS=8 and FRAMES_PER_IMG=1 (so the image wrap fits a short run).
// Rows 0-3 use constant ROM vectors from a table; later rows use an
// address/image-dependent ROM pattern. Expected shift data is queued when a
// row's ROM contents are set up and popped on each panel_clk rising edge.
module tb_panel_scan;
  localparam int PB        = 4;
  localparam int BT        = 8;
  localparam int FPI       = 1;
  localparam int FRAME_CYC = 5120;
  localparam int NROWS     = 72;   // 9 frames: image 0..7 then back to 0
`ifdef PANEL_SCAN_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;
  logic [2:0] panel_a;
  logic       panel_clk, panel_lat, panel_oe_n, frame_start;

  panel_scan_if rom_if ();

  logic        use_pat = 1'b0;
  logic [23:0] c_top = '0;
  logic [23:0] c_bot = '0;

  function automatic logic [23:0] pat(input logic [8:0] a, input logic [2:0] im);
    logic [7:0] r, g, b;
    r = {a[3:0], a[4], a[7:5]};
    g = {a[7:5], a[4:0]} ^ {8{a[8]}};
    b = {im, a[8], a[3:0]};
    return {r, g, b};
  endfunction

  assign rom_if.rgb = use_pat ? pat(rom_if.addr, rom_if.img)
                              : (rom_if.addr[8] ? c_bot : c_top);

  panel_scan #(.PWM_BITS(PB), .BASE_TICKS(BT), .FRAMES_PER_IMG(FPI)) dut (
    .clk(clk), .rst_n(rst_n), .rom(rom_if),
    .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
    .panel_r2(panel_r2), .panel_g2(panel_g2), .panel_b2(panel_b2),
    .panel_a(panel_a), .panel_clk(panel_clk), .panel_lat(panel_lat),
    .panel_oe_n(panel_oe_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_img(input int f);
    if (ANIM) return (f / FPI) % 8;
    return 0;
  endfunction

  // Expected {r1,g1,b1,r2,g2,b2} for the pattern ROM: channel bit 4+p.
  function automatic logic [5:0] pat_bits(input int row, input int p, input int col,
                                          input int im);
    logic [23:0] t, b;
    t = pat({1'b0, 3'(row), 5'(col)}, 3'(im));
    b = pat({1'b1, 3'(row), 5'(col)}, 3'(im));
    return {t[20+p], t[12+p], t[4+p], b[20+p], b[12+p], b[4+p]};
  endfunction

  typedef struct {
    logic [23:0]      top;
    logic [23:0]      bot;
    logic [3:0][5:0]  exp;   // per plane {r1,g1,b1,r2,g2,b2}
  } vec_t;
  vec_t vecs [4];

  logic [5:0] sb_q [$];
  logic       mon_en = 1'b0;
  logic       sb_en  = 1'b0;

  task automatic setup_row(input int i);
    int row, im;
    row = i % 8;
    im  = exp_img(i / 8);
    if (i < 4) begin
      use_pat = 1'b0;
      c_top   = vecs[i].top;
      c_bot   = vecs[i].bot;
    end else begin
      use_pat = 1'b1;
    end
    for (int p = 0; p < PB; p++)
      for (int c = 0; c < 32; c++)
        if (i < 4) sb_q.push_back(vecs[i].exp[p]);
        else       sb_q.push_back(pat_bits(row, p, c, im));
  endtask

  task automatic wait_lat(input int n);
    int got;
    got = 0;
    for (int k = 0; k < 3000 && got < n; k++) begin
      @(negedge clk);
      if (panel_lat) got++;
    end
    chk("lat_count", got, n);
  endtask

  // Cycle-exact check of the first plane after a reset release.
  task automatic check_first_plane();
    int ph, c;
    for (int n = 1; n <= 139; n++) begin
      @(posedge clk);
      #1;
      ph = (n - 1) % 4;
      c  = (n - 1) / 4;
      if (n <= 128) begin
        chk("seq_addr", rom_if.addr, (ph == 0) ? c : 256 + c);
        chk("seq_pclk", panel_clk, (ph == 3) ? 1 : 0);
        chk("seq_oe_n", panel_oe_n, 1);
        chk("seq_lat", panel_lat, 0);
        chk("seq_fs", frame_start, (n == 1) ? 1 : 0);
        if (n == 1) chk("seq_img", rom_if.img, 0);
      end else if (n == 129) begin
        chk("blank_pclk", panel_clk, 0);
        chk("blank_oe_n", panel_oe_n, 1);
        chk("blank_lat", panel_lat, 0);
      end else if (n == 130) begin
        chk("latch_lat", panel_lat, 1);
        chk("latch_a", panel_a, 0);
        chk("latch_pclk", panel_clk, 0);
        chk("latch_oe_n", panel_oe_n, 1);
      end else if (n <= 138) begin
        chk("disp_oe_n", panel_oe_n, 0);
        chk("disp_lat", panel_lat, 0);
      end else begin
        chk("next_oe_n", panel_oe_n, 1);
        chk("next_addr", rom_if.addr, 0);
        chk("next_fs", frame_start, 0);
      end
    end
  endtask

  // Continuous monitor: scoreboard pops, display run lengths, latch row,
  // frame_start period/width and image select per frame.
  int   run_len = 0, run_idx = 0, lat_idx = 0, fs_gap = 0, frame_idx = 0;
  logic prev_clk = 1'b0, prev_oe = 1'b1, prev_fs = 1'b0, fs_seen = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      fs_gap++;
      if (panel_clk && !prev_clk && sb_en) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("shift_data",
                 {panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2},
                 sb_q.pop_front());
      end
      if (!panel_oe_n) run_len++;
      else if (!prev_oe) begin
        chk("oe_run", run_len, BT << (run_idx % PB));
        run_idx++;
        run_len = 0;
      end
      if (panel_lat) begin
        chk("lat_row", panel_a, (lat_idx / PB) % 8);
        chk("lat_oe_n", panel_oe_n, 1);
        chk("img_steady", rom_if.img, exp_img(frame_idx - 1));
        lat_idx++;
      end
      if (frame_start) begin
        chk("fs_width", prev_fs, 0);
        if (fs_seen) chk("fs_period", fs_gap, FRAME_CYC);
        chk("fs_img", rom_if.img, exp_img(frame_idx));
        fs_seen   = 1'b1;
        fs_gap    = 0;
        frame_idx++;
      end
    end
    prev_clk = panel_clk;
    prev_oe  = panel_oe_n;
    prev_fs  = frame_start;
  end

  initial begin
    int found;
    vecs[0] = '{top: 24'hF0_0F_80, bot: 24'h00_FF_00,
                exp: {6'b101010, 6'b100010, 6'b100010, 6'b100010}};
    vecs[1] = '{top: 24'h00_00_00, bot: 24'hFF_FF_FF,
                exp: {6'b000111, 6'b000111, 6'b000111, 6'b000111}};
    vecs[2] = '{top: 24'hA5_5A_3C, bot: 24'h12_34_C8,
                exp: {6'b100001, 6'b010001, 6'b101010, 6'b011110}};
    vecs[3] = '{top: 24'hFF_FF_FF, bot: 24'h30_C0_50,
                exp: {6'b111010, 6'b111011, 6'b111100, 6'b111101}};

    rst_n = 1'b0;
    setup_row(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe_n", panel_oe_n, 1);
    chk("rst_lat", panel_lat, 0);
    chk("rst_pclk", panel_clk, 0);
    chk("rst_addr", rom_if.addr, 0);
    chk("rst_img", rom_if.img, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_a", panel_a, 0);
    chk("rst_data", {panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2}, 0);

    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    sb_en  = 1'b1;
    check_first_plane();
    wait_lat(3);
    for (int i = 1; i < NROWS; i++) begin
      setup_row(i);
      wait_lat(4);
    end
    sb_en = 1'b0;
    chk("sb_drained", sb_q.size(), 0);

    found = 0;
    for (int k = 0; k < 6000 && found == 0; k++) begin
      @(negedge clk);
      if (panel_a == 3'd3 && !panel_oe_n) found = 1;
    end
    chk("find_row3_display", found, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_oe_n", panel_oe_n, 1);
    chk("async_lat", panel_lat, 0);
    chk("async_addr", rom_if.addr, 0);
    chk("async_img", rom_if.img, 0);
    chk("async_a", panel_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_first_plane();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/panel_scan.md
# panel_scan

HUB75 scan driver for the 32x16 RGB LED panel. It sits directly downstream of the 8-image pixel ROM. It generates the ROM pixel address and image select, reads back 24-bit RGB, and serialises binary-code-modulated bit planes onto the panel's 1/8-scan interface. It also steps the displayed image once every fixed number of refreshes.

## Interface
Parameters:
- PWM_BITS, 4: bit planes per colour channel; the top PWM_BITS bits of each 8-bit channel are used (1..8).
- BASE_TICKS, 8: display-enable cycles for plane 0; plane p displays BASE_TICKS<<p cycles.
- FRAMES_PER_IMG, 16: full panel refreshes per animation step (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rgb  in  24  ROM pixel, combinational response to addr/img; R=[23:16], G=[15:8], B=[7:0].
- addr  out  9  ROM pixel address {row[3:0], col[4:0]}.
- img  out  3  ROM image select.
- panel_r1, panel_g1, panel_b1  out  1 each  upper-half (rows 0-7) serial data.
- panel_r2, panel_g2, panel_b2  out  1 each  lower-half (rows 8-15) serial data.
- panel_a  out  3  row-pair select.
- panel_clk  out  1  shift clock; panel samples on rising edge.
- panel_lat  out  1  latch strobe, active high.
- panel_oe_n  out  1  output enable, active low.
- frame_start  out  1  one-cycle pulse on the first SHIFT cycle of each frame.

## Operation
- Loop order: row r 0..7 (outer), plane p 0..PWM_BITS-1, column c 0..31 (inner).
- FSM states: SHIFT -> BLANK -> LATCH -> DISPLAY -> SHIFT.
- SHIFT: four cycles per column, by phase:
  - ph0: addr={1'b0,r,c}.
  - ph1: capture top rgb; addr={1'b1,r,c}.
  - ph2: capture bottom rgb; drive the six data outputs; panel_clk=0.
  - ph3: panel_clk=1, data held.
  - After c=31 ph3, go to BLANK.
- Data bit for plane p = channel bit (8-PWM_BITS+p); x1 from the top capture, x2 from the bottom capture.
- BLANK (1 cycle): panel_oe_n=1; panel_clk=0; panel_a<=r.
- LATCH (1 cycle): panel_lat=1.
- DISPLAY: panel_oe_n=0 for exactly BASE_TICKS<<p cycles; counter width ceil(log2(BASE_TICKS<<(PWM_BITS-1)))+1.
- After DISPLAY:
  - p increments; on the last plane p wraps to 0 and r increments.
  - On r=7 and the last plane, the frame ends: frame_cnt increments, and the next SHIFT cycle pulses frame_start.
- Animation: when frame_cnt wraps at FRAMES_PER_IMG-1, img increments, 7 wraps to 0. img changes only at a frame boundary, never mid-frame.
- panel_oe_n is 1 in every state except DISPLAY. panel_lat is 1 only in LATCH.

## Timing
- Reset values: addr=0, img=0, six data outputs=0, panel_a=0, panel_clk=0, panel_lat=0, panel_oe_n=1, frame_start=0. FSM=SHIFT, r=p=c=phase=0, frame_cnt=0.
- Reset asserts asynchronously: panel_oe_n goes 1 immediately, including mid-DISPLAY.
- First rising edge after release: frame_start=1, addr=0.
- ROM read latency: zero. rgb is sampled on the edge ending the cycle in which addr was presented.
- Plane length: 128 SHIFT + 1 BLANK + 1 LATCH + (BASE_TICKS<<p) cycles.
- Defaults: row = 520+8+16+32+64 = 640 cycles; frame = 5120 cycles; image step = 81920 cycles.
- panel_lat rises only after the last panel_clk rising edge; one cycle separates them (BLANK).
- Outputs are registered; no combinational path from rgb to panel pins.

## Configuration
- PANEL_SCAN_ANIM_EN defined: img advances as described under Operation.
- PANEL_SCAN_ANIM_EN undefined: img is constant 3'd0 and frame_cnt logic is removed. All other timing, including frame_start, is unchanged.

## Test plan
- Reset: hold rst_n=0 -> panel_oe_n=1, panel_lat=0, panel_clk=0, addr=0, img=0. Release -> frame_start high for exactly 1 cycle on the first edge.
- Address/shift sequence: first plane of row 0 -> addr sequence 0,256,1,257,...,31,287. Exactly 32 panel_clk rising edges, then 1 panel_lat pulse with panel_a=0.
- Bit planes: ROM model returns top=24'hF0_0F_80, bottom=24'h00_FF_00 (PWM_BITS=4).
  - r1=1 on all planes; g1=0; b1=1 only on plane 3.
  - g2=1 on all planes; r2=b2=0.
- Display weighting: panel_oe_n low runs of 8,16,32,64 cycles per row. panel_a steps 0..7. frame_start period exactly 5120 cycles.
- Animation with PANEL_SCAN_ANIM_EN: img=1 after 16 frames, and img=0 again after 128 frames (7->0 wrap). Without the macro, img=0 throughout.
- Mid-operation reset: assert rst_n during DISPLAY of row 3 -> panel_oe_n=1 with no clock edge. After release, the scan restarts at row 0, addr=0, img=0.
